// File: rtl/vc_rr_pop_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vc_rr_pop_arbiter_pkg
//  Description : Shared constants, control-state encodings and helpers for
//                the per-VC round-robin pop arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package vc_rr_pop_arbiter_pkg;

    localparam int N_IN = 4;    // number of input FIFOs (fixed for this revision)
    localparam int DW   = 12;   // FIFO word width
    localparam int CNTW = 8;    // transferred-word counter width

    // Global one-hot control state
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } ctrl_state_e;

    // One-hot (at most one bit set) to binary index
    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        onehot4_to_idx = {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_rr_pop_arbiter_rr_grant4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant4
//  Description : Combinational 4-way round-robin picker. Returns the first
//                requesting index scanning i_ptr, i_ptr+1, ... modulo 4.
//  Ports       : i_req[3:0]   request vector
//                i_ptr[1:0]   highest-priority index this cycle
//                o_gnt_valid  at least one request present
//                o_gnt_idx    granted index (i_ptr when nothing requests)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_gnt_valid,
    output logic [1:0] o_gnt_idx
);

    logic [1:0] w_idx;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester to i_ptr is the last (winning) assignment.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = i_ptr;
        w_idx       = i_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vc_rr_pop_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vc_rr_pop_arbiter
//  Description : Round-robin pops one non-empty per-VC input FIFO per cycle
//                and pushes the word into a single output FIFO, honouring
//                output almost_full and the global control state.
//  Ports       : clk, reset      clock / synchronous active-high reset
//                state[3:0]      one-hot control state (RESET/INIT/IDLE/ACTIVE)
//                in_empty, in_data   per-input FIFO status and data_out
//                out_afull       output FIFO almost_full
//                in_pop          registered one-hot pop to input FIFOs
//                out_push, out_data  registered push and word to output FIFO
//                grant_id        source input of the word on out_data
//                xfer_cnt        words pushed since reset (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module vc_rr_pop_arbiter
    import vc_rr_pop_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    input  logic [N_IN-1:0]      in_empty,
    input  logic [N_IN*DW-1:0]   in_data,
    input  logic                 out_afull,
    output logic [N_IN-1:0]      in_pop,
    output logic                 out_push,
    output logic [DW-1:0]        out_data,
    output logic [1:0]           grant_id,
    output logic [CNTW-1:0]      xfer_cnt
);

    logic [DW-1:0]   w_in_word [N_IN];

    logic            w_rst;
    logic            w_grant;
    logic [3:0]      w_req;
    logic            w_gnt_valid;
    logic [1:0]      w_gnt_idx;

    logic [3:0]      r_in_pop_q,   w_in_pop_d;
    logic [1:0]      r_rr_ptr_q,   w_rr_ptr_d;
    logic            r_v1_q,       w_v1_d;
    logic [1:0]      r_sel_q,      w_sel_d;
    logic            r_out_push_q, w_out_push_d;
    logic [DW-1:0]   r_out_data_q, w_out_data_d;
    logic [1:0]      r_grant_id_q, w_grant_id_d;
    logic [CNTW-1:0] r_xfer_cnt_q, w_xfer_cnt_d;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
        assign w_in_word[gi] = in_data[gi*DW +: DW];
    end

    assign w_rst = reset | (state == ST_RESET);

    // An input popped last cycle has not yet updated its empty flag, so it
    // is excluded to avoid popping a 1-deep FIFO twice.
    assign w_req   = ~in_empty & ~r_in_pop_q;
    assign w_grant = (state == ST_ACTIVE) & ~out_afull & w_gnt_valid;

    rr_grant4 u_rr_grant4 (
        .i_req       (w_req),
        .i_ptr       (r_rr_ptr_q),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    always_comb begin
        // Grant stage
        w_in_pop_d = '0;
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_grant) begin
            w_in_pop_d[w_gnt_idx] = 1'b1;
            w_rr_ptr_d            = w_gnt_idx + 2'd1;
        end

        // Stage 1: remember which FIFO was popped; its data appears next cycle
        w_v1_d  = |r_in_pop_q;
        w_sel_d = onehot4_to_idx(r_in_pop_q);

        // Stage 2: capture the returned word and push it; keeps draining in
        // INIT/IDLE so already-popped words are never lost
        w_out_push_d = r_v1_q;
        w_out_data_d = r_out_data_q;
        w_grant_id_d = r_grant_id_q;
        w_xfer_cnt_d = r_xfer_cnt_q;
        if (r_v1_q) begin
            w_out_data_d = w_in_word[r_sel_q];
            w_grant_id_d = r_sel_q;
            w_xfer_cnt_d = r_xfer_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_in_pop_q   <= '0;
            r_rr_ptr_q   <= '0;
            r_v1_q       <= 1'b0;
            r_sel_q      <= '0;
            r_out_push_q <= 1'b0;
            r_out_data_q <= '0;
            r_grant_id_q <= '0;
            r_xfer_cnt_q <= '0;
        end else begin
            r_in_pop_q   <= w_in_pop_d;
            r_rr_ptr_q   <= w_rr_ptr_d;
            r_v1_q       <= w_v1_d;
            r_sel_q      <= w_sel_d;
            r_out_push_q <= w_out_push_d;
            r_out_data_q <= w_out_data_d;
            r_grant_id_q <= w_grant_id_d;
            r_xfer_cnt_q <= w_xfer_cnt_d;
        end
    end

    assign in_pop   = r_in_pop_q;
    assign out_push = r_out_push_q;
    assign out_data = r_out_data_q;
    assign grant_id = r_grant_id_q;
    assign xfer_cnt = r_xfer_cnt_q;

endmodule
`default_nettype wire
